// File: rtl/toast_pkg.sv
// toast_pkg: shared load-type encodings and default widths for the Toast RV32I core.
package toast_pkg;
  localparam int TOAST_XLEN      = 32;
  localparam int TOAST_REGADDR_W = 5;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
endpackage

// File: rtl/toast_wb_fifo.sv
// toast_wb_fifo: synchronous FIFO queuing AUX results for the writeback port.
module toast_wb_fifo
  import toast_pkg::*;
#(
  parameter int WIDTH = TOAST_REGADDR_W + TOAST_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0] count_d, count_q;
  logic do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push_i & !full_o;
    do_pop   = pop_i & !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/toast_wb_unit.sv
// toast_wb_unit: formats MEM loads and merges queued AUX results onto the register-file write port.
module toast_wb_unit
  import toast_pkg::*;
#(
  parameter int XLEN      = TOAST_XLEN,
  parameter int REGADDR_W = TOAST_REGADDR_W,
  parameter int AUX_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       MEM_valid_i,
  input  logic [REGADDR_W-1:0]       MEM_rd_addr_i,
  input  logic                       MEM_rd_wr_en_i,
  input  logic                       MEM_memtoreg_i,
  input  logic [XLEN-1:0]            MEM_alu_result_i,
  input  logic [XLEN-1:0]            MEM_dout_i,
  input  logic [2:0]                 MEM_funct3_i,
  input  logic [1:0]                 MEM_byte_off_i,
  input  logic                       AUX_valid_i,
  input  logic [REGADDR_W-1:0]       AUX_rd_addr_i,
  input  logic [XLEN-1:0]            AUX_data_i,
  output logic                       AUX_ready_o,
  output logic                       WB_stall_o,
  output logic [REGADDR_W-1:0]       WB_rd_addr_o,
  output logic [XLEN-1:0]            WB_rd_wr_data_o,
  output logic                       WB_rd_wr_en_o,
  output logic [$clog2(AUX_DEPTH):0] WB_aux_count_o
);
  localparam int EW = REGADDR_W + XLEN;
  logic mreq, push, pop, fifo_full, fifo_empty;
  logic [EW-1:0] head;
  logic [REGADDR_W-1:0] head_addr;
  logic [XLEN-1:0] head_data, load_val, mem_result;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic rd_wr_en_d, rd_wr_en_q;
  logic [REGADDR_W-1:0] rd_addr_d, rd_addr_q;
  logic [XLEN-1:0] rd_data_d, rd_data_q;
  toast_wb_fifo #(.WIDTH(EW), .DEPTH(AUX_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({AUX_rd_addr_i, AUX_data_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (WB_aux_count_o)
  );
  assign head_addr = head[EW-1:XLEN];
  assign head_data = head[XLEN-1:0];
  // Halfword lane uses off[1] only; misaligned halfwords are trapped upstream.
  always_comb begin
    lane_b     = MEM_dout_i[{MEM_byte_off_i, 3'b000} +: 8];
    lane_h     = MEM_byte_off_i[1] ? MEM_dout_i[16 +: 16] : MEM_dout_i[0 +: 16];
    load_val   = MEM_funct3_i == FUNCT3_LB  ? {{(XLEN-8){lane_b[7]}}, lane_b} :
                 MEM_funct3_i == FUNCT3_LBU ? {{(XLEN-8){1'b0}}, lane_b} :
                 MEM_funct3_i == FUNCT3_LH  ? {{(XLEN-16){lane_h[15]}}, lane_h} :
                 MEM_funct3_i == FUNCT3_LHU ? {{(XLEN-16){1'b0}}, lane_h} :
                 MEM_dout_i;
    mem_result = MEM_memtoreg_i ? load_val : MEM_alu_result_i;
  end
  // A full FIFO steals the port from MEM; otherwise MEM wins and AUX fills idle slots.
  always_comb begin
    mreq       = MEM_valid_i & MEM_rd_wr_en_i & (MEM_rd_addr_i != '0);
    pop        = !fifo_empty & (fifo_full | !mreq);
    push       = AUX_valid_i & !fifo_full;
    rd_wr_en_d = pop ? (head_addr != '0) : mreq;
    rd_addr_d  = !rd_wr_en_d ? '0 : pop ? head_addr : MEM_rd_addr_i;
    rd_data_d  = !rd_wr_en_d ? '0 : pop ? head_data : mem_result;
  end
  assign AUX_ready_o = !fifo_full;
  assign WB_stall_o  = mreq & fifo_full;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wr_en_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_wr_en_q <= rd_wr_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign WB_rd_wr_en_o   = rd_wr_en_q;
  assign WB_rd_addr_o    = rd_addr_q;
  assign WB_rd_wr_data_o = rd_data_q;
endmodule

// File: tb/tb_toast_wb_unit.sv
// tb_toast_wb_unit: directed and randomized checks of toast_wb_unit against a queue-based model.
module tb_toast_wb_unit;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int D    = 4;
  localparam int CW   = 3;
  typedef struct {
    logic [RW-1:0]   a;
    logic [XLEN-1:0] d;
  } ent_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic MEM_valid_i = 0, MEM_rd_wr_en_i = 0, MEM_memtoreg_i = 0;
  logic [RW-1:0] MEM_rd_addr_i = '0;
  logic [XLEN-1:0] MEM_alu_result_i = '0, MEM_dout_i = '0;
  logic [2:0] MEM_funct3_i = '0;
  logic [1:0] MEM_byte_off_i = '0;
  logic AUX_valid_i = 0;
  logic [RW-1:0] AUX_rd_addr_i = '0;
  logic [XLEN-1:0] AUX_data_i = '0;
  logic AUX_ready_o, WB_stall_o, WB_rd_wr_en_o;
  logic [RW-1:0] WB_rd_addr_o;
  logic [XLEN-1:0] WB_rd_wr_data_o;
  logic [CW-1:0] WB_aux_count_o;
  int tests = 0;
  int fails = 0;
  ent_t q[$];

  toast_wb_unit #(.XLEN(XLEN), .REGADDR_W(RW), .AUX_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MEM_valid_i(MEM_valid_i), .MEM_rd_addr_i(MEM_rd_addr_i), .MEM_rd_wr_en_i(MEM_rd_wr_en_i),
    .MEM_memtoreg_i(MEM_memtoreg_i), .MEM_alu_result_i(MEM_alu_result_i), .MEM_dout_i(MEM_dout_i),
    .MEM_funct3_i(MEM_funct3_i), .MEM_byte_off_i(MEM_byte_off_i),
    .AUX_valid_i(AUX_valid_i), .AUX_rd_addr_i(AUX_rd_addr_i), .AUX_data_i(AUX_data_i),
    .AUX_ready_o(AUX_ready_o), .WB_stall_o(WB_stall_o), .WB_rd_addr_o(WB_rd_addr_o),
    .WB_rd_wr_data_o(WB_rd_wr_data_o), .WB_rd_wr_en_o(WB_rd_wr_en_o), .WB_aux_count_o(WB_aux_count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [XLEN-1:0] ref_load(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [XLEN-1:0] bs, hs;
    bs = w >> (8 * off);
    hs = w >> (16 * off[1]);
    case (f3)
      3'd0: return {{24{bs[7]}}, bs[7:0]};
      3'd4: return {24'd0, bs[7:0]};
      3'd1: return {{16{hs[15]}}, hs[15:0]};
      3'd5: return {16'd0, hs[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_idle();
    MEM_valid_i = 0; MEM_rd_wr_en_i = 0; MEM_rd_addr_i = '0; MEM_memtoreg_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    #3;
    tests++;
    if (WB_rd_wr_en_o !== 1'b0 || WB_rd_addr_o !== '0 || WB_rd_wr_data_o !== '0 || WB_stall_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: en=%b addr=%0d data=%h stall=%b, need all 0", WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_stall_o);
    end
    tick();
    rst_i = 0;
    #1;
    tests++;
    if (WB_aux_count_o !== '0 || AUX_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_fifo: count=%0d ready=%b, need count 0 ready 1", WB_aux_count_o, AUX_ready_o);
    end
  endtask

  task automatic test_load_format();
    logic [2:0] f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0] offs [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [XLEN-1:0] exps [5] = '{32'hFFFF_FFA5, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_F0A5, 32'h8000_F0A5};
    for (int i = 0; i < 5; i++) begin
      MEM_valid_i = 1; MEM_rd_wr_en_i = 1; MEM_memtoreg_i = 1; MEM_rd_addr_i = 5'd5;
      MEM_dout_i = 32'h8000_F0A5; MEM_funct3_i = f3s[i]; MEM_byte_off_i = offs[i];
      MEM_alu_result_i = 32'hDEAD_BEEF;
      tick();
      tests++;
      if (WB_rd_wr_en_o !== 1'b1 || WB_rd_addr_o !== 5'd5 || WB_rd_wr_data_o !== exps[i]) begin
        fails++;
        $display("FAIL load_fmt[%0d]: en=%b addr=%0d data=%h, need en=1 addr=5 data=%h", i, WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o, exps[i]);
      end
    end
    mem_idle();
    tick();
  endtask

  task automatic test_x0();
    int seen = 0;
    MEM_valid_i = 1; MEM_rd_wr_en_i = 1; MEM_rd_addr_i = '0; MEM_alu_result_i = 32'h1234;
    AUX_valid_i = 1; AUX_rd_addr_i = '0; AUX_data_i = 32'h5555;
    tick();
    seen += WB_rd_wr_en_o;
    mem_idle();
    AUX_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen += WB_rd_wr_en_o;
    end
    tests++;
    if (seen != 0 || WB_aux_count_o !== '0) begin
      fails++;
      $display("FAIL x0_suppress: writes=%0d count=%0d, need 0 writes count 0", seen, WB_aux_count_o);
    end
  endtask

  task automatic test_aux_drain();
    logic [RW-1:0] ea;
    logic [XLEN-1:0] ed;
    logic ee;
    for (int c = 0; c < 5; c++) begin
      AUX_valid_i = c < 3;
      AUX_rd_addr_i = RW'(c + 1);
      AUX_data_i = 32'(8'h11 * (c + 1));
      tick();
      ee = c >= 1 && c <= 3;
      ea = ee ? RW'(c) : '0;
      ed = ee ? 32'(8'h11 * c) : '0;
      tests++;
      if (WB_rd_wr_en_o !== ee || (ee && (WB_rd_addr_o !== ea || WB_rd_wr_data_o !== ed))) begin
        fails++;
        $display("FAIL aux_drain[%0d]: en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h", c, WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o, ee, ea, ed);
      end
    end
    AUX_valid_i = 0;
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 4; i++) begin
      MEM_valid_i = 1; MEM_rd_wr_en_i = 1; MEM_memtoreg_i = 0; MEM_rd_addr_i = 5'd7;
      MEM_alu_result_i = 32'h100 + i;
      AUX_valid_i = 1; AUX_rd_addr_i = RW'(10 + i); AUX_data_i = 32'hA0 + i;
      tick();
      tests++;
      if (WB_rd_wr_en_o !== 1'b1 || WB_rd_addr_o !== 5'd7 || WB_rd_wr_data_o !== 32'h100 + i) begin
        fails++;
        $display("FAIL full_fill[%0d]: en=%b addr=%0d data=%h, need MEM write rd 7", i, WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o);
      end
    end
    AUX_valid_i = 0;
    MEM_alu_result_i = 32'h200;
    @(negedge clk_i);
    tests++;
    if (AUX_ready_o !== 1'b0 || WB_aux_count_o !== 3'd4 || WB_stall_o !== 1'b1) begin
      fails++;
      $display("FAIL full_state: ready=%b count=%0d stall=%b, need ready 0 count 4 stall 1", AUX_ready_o, WB_aux_count_o, WB_stall_o);
    end
    tick();
    tests++;
    if (WB_rd_wr_en_o !== 1'b1 || WB_rd_addr_o !== 5'd10 || WB_rd_wr_data_o !== 32'hA0) begin
      fails++;
      $display("FAIL full_pop: en=%b addr=%0d data=%h, need en 1 addr 10 data a0", WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o);
    end
    @(negedge clk_i);
    tests++;
    if (WB_stall_o !== 1'b0 || AUX_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL full_release: stall=%b ready=%b, need stall 0 ready 1", WB_stall_o, AUX_ready_o);
    end
    tick();
    tests++;
    if (WB_rd_wr_en_o !== 1'b1 || WB_rd_addr_o !== 5'd7 || WB_rd_wr_data_o !== 32'h200) begin
      fails++;
      $display("FAIL full_retry: en=%b addr=%0d data=%h, need en 1 addr 7 data 200", WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o);
    end
    mem_idle();
    n = 0;
    while (WB_aux_count_o !== '0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    tests++;
    if (WB_aux_count_o !== '0) begin
      fails++;
      $display("FAIL full_drain: count=%0d after %0d cycles, need 0", WB_aux_count_o, n);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    MEM_valid_i = 1; MEM_rd_wr_en_i = 1; MEM_memtoreg_i = 0; MEM_rd_addr_i = 5'd9; MEM_alu_result_i = 32'h99;
    for (int i = 0; i < 2; i++) begin
      AUX_valid_i = 1; AUX_rd_addr_i = RW'(3 + i); AUX_data_i = 32'h30 + i;
      tick();
    end
    AUX_valid_i = 0;
    #2;
    rst_i = 1;
    #1;
    tests++;
    if (WB_rd_wr_en_o !== 1'b0 || WB_rd_addr_o !== '0 || WB_rd_wr_data_o !== '0 || WB_aux_count_o !== '0) begin
      fails++;
      $display("FAIL reset_mid: en=%b addr=%0d data=%h count=%0d, need all 0", WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o, WB_aux_count_o);
    end
    mem_idle();
    tick();
    rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen += WB_rd_wr_en_o;
    end
    tests++;
    if (seen != 0 || WB_aux_count_o !== '0) begin
      fails++;
      $display("FAIL reset_stale: writes=%0d count=%0d, need 0 and 0", seen, WB_aux_count_o);
    end
  endtask

  task automatic test_random();
    logic held = 0;
    logic mreq, full, pop_it, ee;
    logic [RW-1:0] ea;
    logic [XLEN-1:0] ed;
    ent_t h;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        MEM_valid_i = $urandom_range(0, 1);
        MEM_rd_wr_en_i = $urandom_range(0, 3) != 0;
        MEM_rd_addr_i = RW'($urandom_range(0, 7));
        MEM_memtoreg_i = $urandom_range(0, 1);
        MEM_alu_result_i = $urandom;
        MEM_dout_i = $urandom;
        MEM_funct3_i = 3'($urandom_range(0, 7));
        MEM_byte_off_i = 2'($urandom_range(0, 3));
      end
      AUX_valid_i = $urandom_range(0, 9) < 6;
      AUX_rd_addr_i = RW'($urandom_range(0, 7));
      AUX_data_i = $urandom;
      @(negedge clk_i);
      mreq = MEM_valid_i && MEM_rd_wr_en_i && MEM_rd_addr_i != 0;
      full = q.size() == D;
      tests++;
      if (WB_stall_o !== (full && mreq) || AUX_ready_o !== !full || WB_aux_count_o !== CW'(q.size())) begin
        fails++;
        $display("FAIL rand_comb[%0d]: stall=%b ready=%b count=%0d, need %b %b %0d", c, WB_stall_o, AUX_ready_o, WB_aux_count_o, full && mreq, !full, q.size());
      end
      pop_it = (full && mreq) || (!mreq && q.size() > 0);
      ee = 0; ea = '0; ed = '0;
      if (pop_it) begin
        h = q.pop_front();
        ee = h.a != 0; ea = h.a; ed = h.d;
      end else if (mreq) begin
        ee = 1; ea = MEM_rd_addr_i;
        ed = MEM_memtoreg_i ? ref_load(MEM_dout_i, MEM_funct3_i, MEM_byte_off_i) : MEM_alu_result_i;
      end
      if (AUX_valid_i && !full) q.push_back('{a: AUX_rd_addr_i, d: AUX_data_i});
      tick();
      tests++;
      if (WB_rd_wr_en_o !== ee || (ee && (WB_rd_addr_o !== ea || WB_rd_wr_data_o !== ed))) begin
        fails++;
        $display("FAIL rand_wb[%0d]: en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h", c, WB_rd_wr_en_o, WB_rd_addr_o, WB_rd_wr_data_o, ee, ea, ed);
      end
      held = full && mreq;
    end
    AUX_valid_i = 0;
    mem_idle();
  endtask

  initial begin
    test_reset();
    test_load_format();
    test_x0();
    test_aux_drain();
    test_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
